// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit in 5-rupee units, per-item prices,
// cancel/refund, and change paid out one 10/5-rupee coin per clock.
module vending_machine_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 10,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {4'd7, 4'd5, 4'd4, 4'd3}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coin,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 buy,
  input  logic                 cancel,
  input  logic [NUM_ITEMS-1:0] sold_out,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 done,
  output logic [SEL_W-1:0]     item,
  output logic [1:0]           change,
  output logic                 coin_reject,
  output logic                 deny,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W-1:0] ONE       = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO       = CREDIT_W'(2);
  localparam logic [CREDIT_W:0]   MAX_CRD_W = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state;
  logic                buy_held;
  logic                buy_req;
  logic [CREDIT_W:0]   coin_units;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] price;
  logic                in_stock;
  logic                can_buy;
  logic [1:0]          pay_coin;
  logic [CREDIT_W-1:0] pay_rest;

  // A buy held across cycles in IDLE is one request; buy_held is cleared
  // while busy so a buy still held on return to IDLE counts as new.
  assign buy_req = buy && !buy_held;

  always_comb begin
    coin_units = '0;
    case (coin)
      2'b01:   coin_units = (CREDIT_W+1)'(1);
      2'b10:   coin_units = (CREDIT_W+1)'(2);
      2'b11:   coin_units = (CREDIT_W+1)'(4);
      default: coin_units = '0;
    endcase
    credit_sum = {1'b0, credit} + coin_units;
    coin_fits  = (credit_sum <= MAX_CRD_W);
  end

  // Indices at or beyond NUM_ITEMS never match, so they read as out of stock.
  always_comb begin
    price    = '0;
    in_stock = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if ({1'b0, sel} == (SEL_W+1)'(i)) begin
        price    = PRICES[i*CREDIT_W +: CREDIT_W];
        in_stock = !sold_out[i];
      end
    end
    can_buy = in_stock && (credit >= price);
  end

  always_comb begin
    pay_coin = 2'b00;
    pay_rest = '0;
    if (credit >= TWO) begin
      pay_coin = 2'b10;
      pay_rest = credit - TWO;
    end else if (credit == ONE) begin
      pay_coin = 2'b01;
      pay_rest = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      done        <= 1'b0;
      item        <= '0;
      change      <= 2'b00;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
      busy        <= 1'b0;
      buy_held    <= 1'b0;
    end else begin
      done        <= 1'b0;
      deny        <= 1'b0;
      coin_reject <= 1'b0;
      change      <= 2'b00;
      case (state)
        IDLE: begin
          buy_held <= buy;
          if (coin != 2'b00 && (cancel || buy_req || !coin_fits))
            coin_reject <= 1'b1;
          if (cancel && credit != '0) begin
            // First refund coin goes out on the same edge that enters CHANGE.
            state  <= CHANGE;
            busy   <= 1'b1;
            change <= pay_coin;
            credit <= pay_rest;
          end else if (buy_req) begin
            if (can_buy) begin
              state  <= VEND;
              busy   <= 1'b1;
              done   <= 1'b1;
              item   <= sel;
              credit <= credit - price;
            end else begin
              deny <= 1'b1;
            end
          end else if (coin != 2'b00 && !cancel && coin_fits) begin
            credit <= credit_sum[CREDIT_W-1:0];
          end
        end
        VEND, CHANGE: begin
          buy_held <= 1'b0;
          if (coin != 2'b00)
            coin_reject <= 1'b1;
          if (credit != '0) begin
            state  <= CHANGE;
            change <= pay_coin;
            credit <= pay_rest;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: a rupee-level reference model predicts each
// cycle's outputs into a queue, which is popped and compared after the edge.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic [1:0] sel = 2'b00;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] sold_out = 4'b0000;
  logic [3:0] credit;
  logic       done;
  logic [1:0] item;
  logic [1:0] change;
  logic       coin_reject;
  logic       deny;
  logic       busy;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .buy(buy), .cancel(cancel),
    .sold_out(sold_out), .credit(credit), .done(done), .item(item),
    .change(change), .coin_reject(coin_reject), .deny(deny), .busy(busy)
  );

  // {credit[3:0], done, item[1:0], change[1:0], coin_reject, deny, busy}
  logic [11:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Model state, kept in rupees.
  int   m_state = 0;  // 0 idle, 1 vend, 2 change
  int   m_rs = 0;
  int   m_item = 0;
  logic m_buy_held = 1'b0;
  int   price_rs[4] = '{15, 20, 25, 35};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic predict();
    int   coin_rs;
    int   chg;
    logic e_done, e_deny, e_rej, new_buy;
    e_done = 0; e_deny = 0; e_rej = 0; chg = 0;
    case (coin)
      2'b01:   coin_rs = 5;
      2'b10:   coin_rs = 10;
      2'b11:   coin_rs = 20;
      default: coin_rs = 0;
    endcase
    if (rst) begin
      m_state = 0; m_rs = 0; m_item = 0; m_buy_held = 0;
    end else if (m_state == 0) begin
      new_buy = buy && !m_buy_held;
      m_buy_held = buy;
      if (coin_rs > 0 && (cancel || new_buy)) e_rej = 1;
      if (cancel && m_rs > 0) begin
        if (m_rs >= 10) begin chg = 2; m_rs -= 10; end
        else begin chg = 1; m_rs -= 5; end
        m_state = 2;
      end else if (new_buy) begin
        if (!sold_out[sel] && m_rs >= price_rs[sel]) begin
          m_rs -= price_rs[sel];
          m_item = sel;
          e_done = 1;
          m_state = 1;
        end else begin
          e_deny = 1;
        end
      end else if (coin_rs > 0 && !cancel) begin
        if (m_rs + coin_rs <= 50) m_rs += coin_rs;
        else e_rej = 1;
      end
    end else begin
      m_buy_held = 0;
      if (coin_rs > 0) e_rej = 1;
      if (m_rs >= 10) begin chg = 2; m_rs -= 10; m_state = 2; end
      else if (m_rs == 5) begin chg = 1; m_rs = 0; m_state = 2; end
      else m_state = 0;
    end
    exp_q.push_back({4'(m_rs / 5), e_done, 2'(m_item), 2'(chg), e_rej, e_deny,
                     logic'(m_state != 0)});
  endtask

  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic b,
                      input logic cn, input logic r);
    logic [11:0] e;
    coin = c; sel = s; buy = b; cancel = cn; rst = r;
    predict();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("credit", 32'(credit), 32'(e[11:8]));
      check("done", 32'(done), 32'(e[7]));
      check("item", 32'(item), 32'(e[6:5]));
      check("change", 32'(change), 32'(e[4:3]));
      check("coin_reject", 32'(coin_reject), 32'(e[2]));
      check("deny", 32'(deny), 32'(e[1]));
      check("busy", 32'(busy), 32'(e[0]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    // Exact price with single 5-rupee coins.
    step(2'b00, 2'b00, 0, 0, 1);
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b00, 2'b00, 1, 0, 0);
    idle(2);
    // Overpay, change 10,10.
    step(2'b11, 2'b00, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0);
    step(2'b00, 2'b01, 1, 0, 0);
    idle(4);
    // Insufficient credit, then sold out.
    step(2'b10, 2'b00, 0, 0, 0);
    step(2'b00, 2'b10, 1, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);
    sold_out = 4'b0001;
    step(2'b00, 2'b00, 1, 0, 0);
    step(2'b00, 2'b00, 1, 0, 0);
    step(2'b00, 2'b00, 1, 0, 0);
    sold_out = 4'b0000;
    idle(1);
    // Overflow at MAX_CREDIT.
    step(2'b00, 2'b00, 0, 0, 1);
    step(2'b11, 2'b00, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0);
    step(2'b10, 2'b00, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0);
    // Cancel refund of 5 units with a coin inserted mid-refund.
    step(2'b00, 2'b00, 0, 0, 1);
    step(2'b11, 2'b00, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b00, 2'b00, 0, 1, 0);
    step(2'b10, 2'b00, 0, 0, 0);
    idle(3);
    // Cancel + buy + coin together, then reset mid-change.
    step(2'b10, 2'b00, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b11, 2'b00, 1, 1, 0);
    step(2'b00, 2'b00, 0, 0, 1);
    idle(2);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) sold_out = 4'($urandom_range(0, 15));
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 9) == 0),
           logic'($urandom_range(0, 79) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
